// File: rtl/running_sum_inverse_if.sv
// Stream bundle for the running-sum inverse: windowed sums in, reconstructed samples out.
interface running_sum_inverse_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int LOG2_SUM_LEN = 6
);
    logic signed [DATA_WIDTH+LOG2_SUM_LEN-1:0] sum_in;
    logic                                      sum_in_valid;
    logic signed [DATA_WIDTH-1:0]              data_out;
    logic                                      data_out_valid;
    logic                                      range_err;

    modport master (
        output sum_in, sum_in_valid,
        input  data_out, data_out_valid, range_err
    );

    modport slave (
        input  sum_in, sum_in_valid,
        output data_out, data_out_valid, range_err
    );
endinterface

// File: rtl/running_sum_inverse.sv
// Rebuilds x[n] from N-sample running sums: x[n] = s[n] - s[n-1] + x[n-N].
// Define RUNNING_SUM_INVERSE_RANGE_CHECK_EN for saturation and a sticky range_err.
module running_sum_inverse #(
    parameter int DATA_WIDTH   = 16,
    parameter int LOG2_SUM_LEN = 6
) (
    input logic clk,
    input logic rstn,
    input logic clear,
    running_sum_inverse_if.slave bus
);
    localparam int N  = 1 << LOG2_SUM_LEN;
    localparam int SW = DATA_WIDTH + LOG2_SUM_LEN;
    localparam int TW = SW + 1;
    localparam int DW = DATA_WIDTH;

    logic                  restart;
    logic signed [SW-1:0]  prev_sum;
    logic [LOG2_SUM_LEN:0] fill_cnt;
    logic [LOG2_SUM_LEN-1:0] wr_ptr;
    logic [LOG2_SUM_LEN-1:0] s1_ptr;
    logic                  s1_valid;
    logic signed [TW-1:0]  s1_diff;
    logic signed [DW-1:0]  s1_xold;
    logic signed [DW-1:0]  line [N];
    logic signed [DW-1:0]  data_q;
    logic                  valid_q;
    logic                  err_q;

    logic signed [TW-1:0]  diff;
    logic signed [TW-1:0]  recon;
    logic signed [DW-1:0]  x_old;
    logic signed [DW-1:0]  sat;
    logic                  err_set;

    assign restart = !rstn || clear;

    // Pointer and fill count advance in stage 1, so the read address is
    // always current; the N-sample-old entry was written long before.
    always_comb begin
        diff  = {bus.sum_in[SW-1], bus.sum_in} - {prev_sum[SW-1], prev_sum};
        x_old = fill_cnt[LOG2_SUM_LEN] ? line[wr_ptr] : '0;
        recon = s1_diff + {{(TW-DW){s1_xold[DW-1]}}, s1_xold};
`ifdef RUNNING_SUM_INVERSE_RANGE_CHECK_EN
        err_set = recon[TW-1:DW-1] != {(TW-DW+1){recon[TW-1]}};
        if (!err_set)
            sat = recon[DW-1:0];
        else if (recon[TW-1])
            sat = {1'b1, {(DW-1){1'b0}}};
        else
            sat = {1'b0, {(DW-1){1'b1}}};
`else
        err_set = 1'b0;
        sat     = recon[DW-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            prev_sum <= '0;
            fill_cnt <= '0;
            wr_ptr   <= '0;
            s1_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_xold  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_valid <= bus.sum_in_valid;
            valid_q  <= s1_valid;
            if (bus.sum_in_valid) begin
                s1_diff  <= diff;
                s1_xold  <= x_old;
                s1_ptr   <= wr_ptr;
                prev_sum <= bus.sum_in;
                wr_ptr   <= wr_ptr + 1'b1;
                if (!fill_cnt[LOG2_SUM_LEN])
                    fill_cnt <= fill_cnt + 1'b1;
            end
            if (s1_valid) begin
                data_q <= sat;
                if (err_set)
                    err_q <= 1'b1;
            end
        end
    end

    // Delay line holds exactly what was emitted, saturated or not.
    always_ff @(posedge clk) begin
        if (s1_valid && !restart)
            line[s1_ptr] <= sat;
    end

    assign bus.data_out       = data_q;
    assign bus.data_out_valid = valid_q;
    assign bus.range_err      = err_q;
endmodule

// File: tb/tb_running_sum_inverse.sv
// Directed bench for running_sum_inverse with a window-sum reference model.
module tb_running_sum_inverse;
    localparam int DW = 16;
    localparam int L  = 6;
    localparam int N  = 1 << L;
    localparam int SW = DW + L;
`ifdef RUNNING_SUM_INVERSE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic clear = 1'b0;

    running_sum_inverse_if #(.DATA_WIDTH(DW), .LOG2_SUM_LEN(L)) bus ();

    running_sum_inverse #(.DATA_WIDTH(DW), .LOG2_SUM_LEN(L)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int exp;
        bit err;
        int due;
    } item_t;

    item_t q[$];
    int    hist[$];
    int    xr[1000];
    int    cyc    = 0;
    int    errors = 0;
    int    checks = 0;
    bit    exp_err = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                     name, cyc, act, req);
        end
    endtask

    // Every cycle: either an expected output is due, or valid must be low.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("out_valid", int'(bus.data_out_valid), 1);
            chk("data_out", int'(bus.data_out), q[0].exp);
            chk("range_err", int'(bus.range_err), int'(q[0].err));
            void'(q.pop_front());
        end else begin
            chk("idle_valid", int'(bus.data_out_valid), 0);
        end
    end

    function automatic int wsum();
        int s = 0;
        int lo = (hist.size() > N) ? hist.size() - N : 0;
        for (int i = lo; i < hist.size(); i++) s += hist[i];
        return s;
    endfunction

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int s, int e);
        item_t it;
        bus.sum_in       = SW'(s);
        bus.sum_in_valid = 1'b1;
        it.exp = e;
        it.err = exp_err;
        it.due = cyc + 2;
        q.push_back(it);
        @(posedge clk);
        #1;
        bus.sum_in_valid = 1'b0;
    endtask

    task automatic push_x(int x, int dens);
        while (dens < 100 && $urandom_range(99) >= dens) idle(1);
        hist.push_back(x);
        send(wsum(), x);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_data", int'(bus.data_out), 0);
        chk("clear_err", int'(bus.range_err), 0);
        q.delete();
        hist.delete();
        exp_err = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_data", int'(bus.data_out), 0);
        chk("rst_valid", int'(bus.data_out_valid), 0);
        chk("rst_err", int'(bus.range_err), 0);
        q.delete();
        hist.delete();
        exp_err = 1'b0;
    endtask

    initial begin
        bus.sum_in       = '0;
        bus.sum_in_valid = 1'b0;
        idle(2);
        chk("init_data", int'(bus.data_out), 0);
        chk("init_valid", int'(bus.data_out_valid), 0);
        chk("init_err", int'(bus.range_err), 0);
        rstn = 1'b1;
        idle(1);

        // Pin the reference model against hand-computed window sums.
        repeat (70) hist.push_back(100);
        chk("model_const", wsum(), 6400);
        hist.delete();
        hist.push_back(-5);
        repeat (63) hist.push_back(0);
        chk("model_imp_in", wsum(), -5);
        hist.push_back(0);
        chk("model_imp_out", wsum(), 0);
        hist.delete();

        // Constant x=100, window fills then holds at 6400.
        for (int i = 0; i < 264; i++)
            send(100 * ((i < N) ? i + 1 : N), 100);
        idle(3);
        do_clear();

        // Impulse -5 then zeros; sample 64 must drop back to 0.
        for (int i = 0; i < 130; i++)
            send((i < N) ? -5 : 0, (i == 0) ? -5 : 0);
        idle(3);
        do_clear();

        // Full-scale random, back-to-back then sparse.
        for (int i = 0; i < 1000; i++)
            xr[i] = int'($urandom_range(65535)) - 32768;
        xr[0] = -32768;
        xr[1] = 32767;
        xr[2] = -32768;
        xr[500] = 32767;
        for (int i = 0; i < 1000; i++) push_x(xr[i], 100);
        idle(3);
        do_clear();
        for (int i = 0; i < 1000; i++) push_x(xr[i], 30);
        idle(3);
        do_clear();

        // Clear mid-stream with samples in flight, then a fresh x=7 stream.
        for (int i = 0; i < 30; i++) push_x(3, 100);
        do_clear();
        for (int i = 0; i < 100; i++) push_x(7, 100);

        // Reset mid-operation, then a fresh random stream.
        for (int i = 0; i < 100; i++) push_x(-9, 100);
        do_reset();
        for (int i = 0; i < 80; i++)
            push_x(int'($urandom_range(65535)) - 32768, 100);
        idle(3);
        do_clear();

        // Out-of-range jump 0 -> 40000.
        send(0, 0);
        exp_err = RC;
        send(40000, RC ? 32767 : -25536);
        for (int i = 0; i < 3; i++) send(40000, 0);
        idle(4);
        chk("range_err_held", int'(bus.range_err), int'(RC));
        do_clear();

        idle(4);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
